// File: rtl/uart_tx_param.sv
// Parametrised asynchronous serial transmitter.
// Accepts a character over a 4-phase Req/Ack handshake and sends it LSB-first as
// start bit, DATA_W data bits, optional parity bit and STOP_BITS stop bits.
// All outputs are registered; they are decoded from the next state so that the
// line changes on the same edge that the state does.
module uart_tx_param #(
  parameter int unsigned DATA_W       = 8,   // 5..9
  parameter int unsigned CLKS_PER_BIT = 16,  // >= 2
  parameter int unsigned PARITY       = 0,   // 0 none, 1 even, 2 odd
  parameter int unsigned STOP_BITS    = 1    // 1 or 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Req,
  input  logic [DATA_W-1:0] char,
  output logic              RxD,
  output logic              Ack,
  output logic              Busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_W);

  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);
  localparam logic            OddPar   = (PARITY == 2);
  localparam logic            HasPar   = (PARITY != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StAck
  } state_e;

  state_e            r_state, w_state;
  logic [CntW-1:0]   r_baud, w_baud;
  logic [BitW-1:0]   r_bit, w_bit;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic              r_par, w_par;
  logic              r_rxd, w_rxd;
  logic              r_ack, w_ack;
  logic              r_busy, w_busy;
  logic              w_tick;

  assign w_tick = (r_baud == CntMax);

  // Next-state logic: baud timing, bit counting, shifting and handshake.
  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_par   = r_par;

    unique case (r_state)
      StIdle: begin
        if (Req) begin
          w_state = StStart;
          w_shift = char;
          w_par   = (^char) ^ OddPar;
          w_baud  = '0;
          w_bit   = '0;
        end
      end
      StStart: begin
        w_baud = w_tick ? '0 : r_baud + 1'b1;
        if (w_tick) begin
          w_state = StData;
        end
      end
      StData: begin
        w_baud = w_tick ? '0 : r_baud + 1'b1;
        if (w_tick) begin
          w_shift = r_shift >> 1;
          if (r_bit == LastData) begin
            w_bit   = '0;
            w_state = HasPar ? StParity : StStop;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
      end
      StParity: begin
        w_baud = w_tick ? '0 : r_baud + 1'b1;
        if (w_tick) begin
          w_state = StStop;
        end
      end
      StStop: begin
        w_baud = w_tick ? '0 : r_baud + 1'b1;
        if (w_tick) begin
          if (r_bit == LastStop) begin
            w_bit   = '0;
            w_state = StAck;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
      end
      StAck: begin
        // Strict 4-phase: only a sampled Req=0 releases the acknowledge.
        if (!Req) begin
          w_state = StIdle;
        end
      end
      default: begin
        w_state = StIdle;
        w_baud  = '0;
        w_bit   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state.
  always_comb begin
    w_rxd  = 1'b1;
    w_ack  = 1'b0;
    w_busy = 1'b0;
    unique case (w_state)
      StStart: begin
        w_rxd  = 1'b0;
        w_busy = 1'b1;
      end
      StData: begin
        w_rxd  = w_shift[0];
        w_busy = 1'b1;
      end
      StParity: begin
        w_rxd  = w_par;
        w_busy = 1'b1;
      end
      StStop: begin
        w_busy = 1'b1;
      end
      StAck: begin
        w_ack = 1'b1;
      end
      default: begin
        w_rxd = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces the line high immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_rxd   <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_rxd   <= w_rxd;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
    end
  end

  assign RxD  = r_rxd;
  assign Ack  = r_ack;
  assign Busy = r_busy;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised serial transmitter: the next generation of the team's fixed 8N1 sender. It takes a parallel character over a 4-phase Req/Ack handshake and shifts it out LSB-first as an asynchronous serial frame. Data width, parity mode, stop-bit count and baud divisor are all configurable. It sits between the packet logic and the serial line that feeds the receiver's RxD input.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  input  1  system clock; all state changes on rising edge
clr  input  1  reset; asynchronous, active-high
Req  input  1  request; level-held by the producer until Ack is seen
char  input  DATA_W  character to send; sampled only on acceptance
RxD  output  1  serial line out; idles high; drives the receiver's RxD
Ack  output  1  frame-complete acknowledge
Busy  output  1  high while a frame is on the line

Behaviour:
- Reset, asynchronous: state IDLE, RxD=1, Ack=0, Busy=0, baud counter=0, bit counter=0. Reset mid-frame aborts the frame; RxD returns high immediately, with no glitch low.
- Frame is: start (0), DATA_W data bits LSB-first, optional parity bit, STOP_BITS stop bits (1).
- P = 0 if PARITY==0, else 1. Frame length F = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles.
- Every bit is held for exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1 of width $clog2(CLKS_PER_BIT). The counter restarts at each bit boundary.
- States: IDLE, START, DATA, PARITY, STOP, ACK.
- IDLE:
  - RxD=1, Busy=0, Ack=0.
  - If Req=1 at edge k: latch char into the shift register, compute parity, go to START.
  - RxD=0 and Busy=1 take effect from edge k (one cycle of latency from Req to line).
- START: after CLKS_PER_BIT cycles go to DATA.
- DATA:
  - RxD = shift[0].
  - Shift right at each bit boundary.
  - After DATA_W bits go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - Even: bit = XOR of the latched data.
  - Odd: bit = its inverse.
  - Held CLKS_PER_BIT cycles.
- STOP:
  - RxD=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At edge k+F go to ACK: Busy=0, Ack=1.
- ACK:
  - RxD=1, Ack=1.
  - Stay while Req=1. When Req is sampled 0, go to IDLE with Ack=0 at that edge.
  - If Req is already 0 when ACK is entered, Ack is high for exactly one cycle.
- The next frame can start no earlier than the edge after the return to IDLE, so there is at least one idle-high cycle between frames.
- char changes after acceptance are ignored. Req changes during START..STOP are ignored; the frame always completes.
- Req=1 held continuously after Ack does not retrigger. Req must drop first (strict 4-phase handshake).
- Busy=1 in START, DATA, PARITY, STOP only. Ack and Busy are never high together.
- All outputs are registered, with no combinational path from Req or char to outputs.

Test Plan:
- Reset/idle: assert clr for 20 ns, then release with Req=0 -> RxD=1, Ack=0, Busy=0 for 100 cycles.
- 8N1, CLKS_PER_BIT=4: char=8'hDB, Req=1 until Ack -> RxD over 40 cycles reads 0,1,1,0,1,1,0,1,1,1 (4 cycles each); Ack rises at cycle 41; Ack falls one edge after Req drops.
- Parity even and odd, DATA_W=8, CLKS_PER_BIT=4:
  - char=8'hDB, even -> parity bit 0, frame 44 cycles.
  - char=8'hDB, odd -> parity bit 1.
  - char=8'h01, even -> parity bit 1.
- Config DATA_W=7, STOP_BITS=2, PARITY=2: char=7'h55 -> 1+7+1+2 = 11 bit-times, parity 1, RxD high for final 8 cycles before Ack.
- Mid-frame disturbance: change char and drop Req during DATA -> transmitted bits match the latched value; Ack pulses for exactly 1 cycle; no new frame starts.
- Reset mid-frame: assert clr during bit 3 -> RxD=1, Busy=0 asynchronously; after release with Req=1, a fresh, complete frame is sent.
